// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_stream serializer.
// PISO_PARITY_EN adds the PARITY state and one extra bit per frame.
package piso_pkg;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    localparam int FRAME_EXTRA = 1;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } piso_state_e;

    localparam int FRAME_EXTRA = 0;
`endif

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_len(input int width);
        return width + FRAME_EXTRA;
    endfunction

endpackage

// File: rtl/piso_stream_if.sv
// Producer-side load handshake and serial-side outputs of piso_stream.
interface piso_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             msb_first;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             frame_done;

    modport master (
        output data_in, load_valid, msb_first,
        input  load_ready, serial_out, serial_valid, busy, frame_done
    );

    modport slave (
        input  data_in, load_valid, msb_first,
        output load_ready, serial_out, serial_valid, busy, frame_done
    );
endinterface

// File: rtl/piso_hold_buf.sv
// One-entry holding register (word + bit order) with a full flag.
module piso_hold_buf
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] data_in,
    input  logic             order_in,
    output logic             full,
    output logic [WIDTH-1:0] data,
    output logic             order
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full  <= 1'b0;
            data  <= '0;
            order <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            data  <= data_in;
            order <= order_in;
        end else if (drain) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out streamer with one-word holding buffer for gapless frames.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
//
// state  | meaning
// IDLE   | nothing shifting, serial_valid low
// SHIFT  | emitting a data bit; cnt_q = data bits still to follow
// PARITY | emitting the parity bit (PISO_PARITY_EN only)
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   reset,
    piso_stream_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             msb_q, msb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             so_q, so_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             hold_full;
    logic             hold_msb;
    logic [WIDTH-1:0] hold_data;

    logic             accept;
    logic             last_bit;
    logic             direct;
    logic             hold_load;
    logic             hold_drain;
    logic             load_en;
    logic [WIDTH-1:0] load_word;
    logic             load_msb;

    assign bus.load_ready = !hold_full && !reset;
    assign accept         = bus.load_valid && bus.load_ready;

`ifdef PISO_PARITY_EN
    assign last_bit = (state_q == PARITY);
`else
    assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
`endif

    // hold_full blocks accept, so a drain and a new hold load never coincide
    assign direct     = accept && ((state_q == IDLE) || (last_bit && !hold_full));
    assign hold_drain = last_bit && hold_full;
    assign hold_load  = accept && !direct;

    piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load),
        .drain    (hold_drain),
        .data_in  (bus.data_in),
        .order_in (bus.msb_first),
        .full     (hold_full),
        .data     (hold_data),
        .order    (hold_msb)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        msb_d     = msb_q;
        cnt_d     = cnt_q;
        so_d      = 1'b0;
`ifdef PISO_PARITY_EN
        par_d     = par_q;
`endif
        load_en   = 1'b0;
        load_word = bus.data_in;
        load_msb  = bus.msb_first;

        if (hold_drain) begin
            load_en   = 1'b1;
            load_word = hold_data;
            load_msb  = hold_msb;
        end else if (direct) begin
            load_en   = 1'b1;
        end

        if (load_en) begin
            // first bit goes straight to the output flop; the rest stays in shreg
            state_d = SHIFT;
            msb_d   = load_msb;
            cnt_d   = CNT_W'(WIDTH - 1);
            so_d    = load_msb ? load_word[WIDTH-1] : load_word[0];
            shreg_d = load_msb ? (load_word << 1) : (load_word >> 1);
`ifdef PISO_PARITY_EN
            par_d   = ^load_word;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q != '0) begin
                        so_d    = msb_q ? shreg_q[WIDTH-1] : shreg_q[0];
                        shreg_d = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
                        cnt_d   = cnt_q - 1'b1;
                    end else begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
                        so_d    = par_q;
`else
                        state_d = IDLE;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: state_d = IDLE;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            msb_q   <= 1'b0;
            cnt_q   <= '0;
            so_q    <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            msb_q   <= msb_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.serial_out   = so_q;
    assign bus.serial_valid = (state_q != IDLE);
    assign bus.frame_done   = last_bit;
    assign bus.busy         = (state_q != IDLE) || hold_full;

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out shifter, the next generation of the team's 4-bit PISO. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word while the current word shifts, so back-to-back frames stream with zero idle cycles. Bit order is selectable per word, and an optional parity bit can be compiled in. It sits between a parallel producer, such as a register file or FIFO, and a single-wire serial link.

## Interface
- WIDTH, 8, data word width (≥2)
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- data_in  input  WIDTH  parallel word
- load_valid  input  1  producer offers data_in
- load_ready  output  1  block can accept a word this cycle
- msb_first  input  1  bit order for the offered word (1 = MSB first); sampled with the word
- serial_out  output  1  current serial bit (registered)
- serial_valid  output  1  serial_out carries a frame bit
- busy  output  1  shifter or holding register occupied
- frame_done  output  1  one-cycle pulse during the last bit of a frame

## Operation
- Transfer occurs when load_valid && load_ready are both high at a rising edge. The word and msb_first are captured together.
- load_ready = !hold_full && !reset.
- Storage:
  - The shifter holds the active word, its order bit, and a bit counter.
  - The holding register holds one pending word and its order bit.
- FSM in the shifter:
  - IDLE → SHIFT on load.
  - SHIFT → PARITY after the last data bit, only when PISO_PARITY_EN is defined.
  - Otherwise SHIFT/PARITY → SHIFT (reload) if a word is pending or accepted; else → IDLE.
- Routing of an accepted word:
  - It goes straight to the shifter if the shifter is IDLE, or is in its final bit cycle with the hold empty.
  - Otherwise it goes to the holding register.
- In the final bit cycle, if the hold is full, the hold moves into the shifter at that edge. The hold then empties, and load_ready rises the next cycle.
- Order handling:
  - MSB-first emits data[WIDTH-1] down to data[0].
  - LSB-first emits data[0] up to data[WIDTH-1].
- When serial_valid = 0, serial_out = 0.
- busy = (state != IDLE) || hold_full.
- Simultaneous load and final bit:
  - If the hold is empty, the new word loads directly into the shifter.
  - If the hold is full, load_ready is already 0, so no transfer is possible.
- Reset mid-frame aborts the frame and discards the pending word. No partial frame resumes after reset.

## Timing
- Reset values:
  - serial_out = 0, serial_valid = 0, frame_done = 0, busy = 0.
  - load_ready is 0 while reset is asserted and 1 from the first cycle after deassertion.
- Latency: the first bit appears on serial_out in the cycle after the accepting edge.
- Each bit is held for exactly one clk cycle.
- Frame length is WIDTH cycles, or WIDTH+1 with parity.
- frame_done is high in the frame's last bit cycle (data or parity) and coincides with serial_valid.
- Back-to-back operation:
  - The next frame's first bit follows the prior frame's last bit with no gap.
  - Sustained throughput is one word per frame length.
- After a transfer into an empty hold, load_ready drops on the next cycle.

## Configuration
- PISO_PARITY_EN defined:
  - An even-parity bit (XOR of all data bits) is emitted after the last data bit, with serial_valid = 1.
  - Frame length is WIDTH+1.
  - frame_done fires on the parity cycle.
- PISO_PARITY_EN undefined: the PARITY state and the parity logic are absent, and frame length is WIDTH.

## Structure
- Package piso_pkg contains:
  - the state enum (IDLE, SHIFT, PARITY);
  - the function for counter width;
  - the localparam for frame length, which depends on PISO_PARITY_EN.
- Sub-module piso_hold_buf is a one-entry data+order register with full flag, load and drain. The top level instantiates it and owns the shifter and FSM.

## Test plan
- Reset, then release with WIDTH=8, load 8'hA5 MSB-first:
  - serial_out is 1,0,1,0,0,1,0,1 on the 8 cycles after acceptance.
  - frame_done fires on cycle 8, then the block returns to idle with busy=0.
- Load 8'hA5 LSB-first: serial_out is 1,0,1,0,0,1,0,1 reversed order per bit index (bits 0..7 = 1,0,1,0,0,1,0,1). Check against data[i].
- Hold load_valid high continuously with words 8'h01, 8'h80, 8'hFF:
  - 24 contiguous serial_valid cycles with no gap.
  - load_ready deasserts while the hold is full.
- Assert reset for one cycle at bit 3 of 8'hC3 with a word pending:
  - All outputs go to 0 immediately.
  - No further bits are emitted.
  - load_ready is 1 after release.
- With PISO_PARITY_EN, load 8'h07:
  - 9-bit frame with parity bit 1.
  - frame_done is on the 9th cycle.
  - 8'h03 gives parity bit 0.
